// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg - shared types and constants for the USB full-speed receive path.
// Holds the receiver control FSM state encoding, the SYNC pattern as it appears
// in the receive shift register, and small decode helpers used by rcv_ctrl.

package usb_rx_pkg;

   // Receiver control FSM states
   typedef enum logic [3:0] {
      IDLE,
      SYNC_WAIT,
      DATA_WAIT,
      STORE,
      BOUNDARY,
      EOP2,
      DONE,
      LINE_WAIT,
      ERR,
      EIDLE
   } rcv_state_t;

   // SYNC field as seen in the shift register once its 8th bit has arrived
   localparam logic [7:0] SYNC_BYTE = 8'h80;

   // A packet is considered in progress from SYNC detection until the line
   // returns to idle after EOP, or until the EOP that terminates an error
   function automatic logic state_is_rcving(input rcv_state_t s);
      return (s == SYNC_WAIT) || (s == DATA_WAIT) || (s == STORE) ||
             (s == BOUNDARY)  || (s == EOP2)      || (s == DONE)  ||
             (s == LINE_WAIT) || (s == ERR);
   endfunction

   // States in which the error flag is forced high
   function automatic logic state_is_error(input rcv_state_t s);
      return (s == ERR) || (s == EIDLE);
   endfunction

endpackage

// File: rtl/rcv_ctrl_if.sv
// rcv_ctrl_if - bundle between the bit-level receive front end / RX FIFO and
// the receiver control unit. The master side is the front end (it produces the
// bit/byte events and consumes the control strobes); the slave side is rcv_ctrl.

interface rcv_ctrl_if;

   logic       d_edge;
   logic       eop;
   logic       shift_enable;
   logic       byte_received;
   logic [7:0] rcv_data;

   logic       rcving;
   logic       w_enable;
   logic       r_error;
   logic       packet_done;

   modport master (
      output d_edge,
      output eop,
      output shift_enable,
      output byte_received,
      output rcv_data,
      input  rcving,
      input  w_enable,
      input  r_error,
      input  packet_done
   );

   modport slave (
      input  d_edge,
      input  eop,
      input  shift_enable,
      input  byte_received,
      input  rcv_data,
      output rcving,
      output w_enable,
      output r_error,
      output packet_done
   );

endinterface

// File: rtl/rcv_ctrl.sv
// rcv_ctrl - USB full-speed receiver control unit.
// Sequences one packet at a time: validates SYNC, strobes one FIFO write per
// data byte, requires EOP to start on a byte boundary and last two bit times,
// and raises a sticky error flag on any protocol violation.
// Optional feature macro: RCV_LEN_CHECK_EN adds a per-packet byte counter and
// the MAX_BYTES parameter; packets longer than MAX_BYTES data bytes are errors.
// Without the macro, packet length is unbounded and no counter is built.

module rcv_ctrl
`ifdef RCV_LEN_CHECK_EN
#(
   parameter int unsigned MAX_BYTES = 64
)
`endif
(
   input  logic       clk,
   input  logic       n_rst,
   rcv_ctrl_if.slave  bus
);

   import usb_rx_pkg::*;

   rcv_state_t state;
   rcv_state_t next_state;
   logic       r_error_q;
   logic       r_error_d;
   logic       len_full;

`ifdef RCV_LEN_CHECK_EN
   localparam int CntW = $clog2(MAX_BYTES + 1);

   logic [CntW-1:0] byte_count;

   // Count stored data bytes for the current packet; restart when a new
   // packet begins so a previous packet's length never leaks forward
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         byte_count <= '0;
      end else if ((state == IDLE) && (next_state != IDLE)) begin
         byte_count <= '0;
      end else if (state == STORE) begin
         byte_count <= byte_count + CntW'(1);
      end
   end

   assign len_full = (byte_count == CntW'(MAX_BYTES));
`else
   assign len_full = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic and the next value of the sticky error flag
   always_comb begin
      next_state = state;
      r_error_d  = 1'b0;

      case (state)
         IDLE: begin
            if (bus.d_edge) begin
               next_state = SYNC_WAIT;
            end
         end

         SYNC_WAIT: begin
            if (bus.eop && bus.shift_enable) begin
               next_state = ERR;
            end else if (bus.byte_received) begin
               if (bus.rcv_data == SYNC_BYTE) begin
                  next_state = DATA_WAIT;
               end else begin
                  next_state = ERR;
               end
            end
         end

         DATA_WAIT: begin
            if (bus.eop && bus.shift_enable) begin
               next_state = ERR;
            end else if (bus.byte_received) begin
               if (len_full) begin
                  next_state = ERR;
               end else begin
                  next_state = STORE;
               end
            end
         end

         STORE: begin
            next_state = BOUNDARY;
         end

         BOUNDARY: begin
            if (bus.shift_enable) begin
               if (bus.eop) begin
                  next_state = EOP2;
               end else begin
                  next_state = DATA_WAIT;
               end
            end
         end

         EOP2: begin
            if (bus.shift_enable) begin
               if (bus.eop) begin
                  next_state = DONE;
               end else begin
                  next_state = ERR;
               end
            end
         end

         DONE: begin
            next_state = LINE_WAIT;
         end

         LINE_WAIT: begin
            if (bus.d_edge) begin
               next_state = IDLE;
            end
         end

         ERR: begin
            if (bus.eop && bus.shift_enable) begin
               next_state = EIDLE;
            end
         end

         EIDLE: begin
            if (bus.d_edge) begin
               next_state = IDLE;
            end
         end

         default: begin
            next_state = IDLE;
         end
      endcase

      // The flag follows the error states and survives the return to IDLE;
      // it only drops when IDLE is left for a new packet
      r_error_d = state_is_error(next_state) ||
                  ((next_state == IDLE) && r_error_q);
   end

   // Sticky error flag register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_error_q <= 1'b0;
      end else begin
         r_error_q <= r_error_d;
      end
   end

   assign bus.rcving      = state_is_rcving(state);
   assign bus.w_enable    = (state == STORE);
   assign bus.packet_done = (state == DONE);
   assign bus.r_error     = r_error_q;

endmodule

// File: tb/tb_rcv_ctrl.sv
// tb_rcv_ctrl - directed testbench for rcv_ctrl.
// Drives bit/byte events cycle by cycle and compares the control outputs with
// hand-derived values. Build with RCV_LEN_CHECK_EN defined to also exercise the
// packet length limit with MAX_BYTES = 2.

module tb_rcv_ctrl;

   logic clk;
   logic n_rst;

   int unsigned check_count;
   int unsigned fail_count;
   int unsigned w_count;
   int unsigned pd_count;
   int unsigned w_base;
   int unsigned pd_base;

   rcv_ctrl_if bus ();

`ifdef RCV_LEN_CHECK_EN
   rcv_ctrl #(.MAX_BYTES(2)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus.slave)
   );
`else
   rcv_ctrl dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus.slave)
   );
`endif

   // Free-running 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count strobe cycles away from the active edge
   always @(negedge clk) begin
      if (bus.w_enable === 1'b1) begin
         w_count = w_count + 1;
      end
      if (bus.packet_done === 1'b1) begin
         pd_count = pd_count + 1;
      end
   end

   // Compare one observed value with its expected value
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      check_count = check_count + 1;
      if (actual !== expected) begin
         fail_count = fail_count + 1;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Present one cycle of inputs, let the DUT clock them in, and return just
   // after the edge with the single-cycle pulses dropped again
   task automatic applyStimulus(input logic de, input logic se, input logic br,
                                input logic e, input logic [7:0] data);
      bus.d_edge        = de;
      bus.shift_enable  = se;
      bus.byte_received = br;
      bus.eop           = e;
      bus.rcv_data      = data;
      @(posedge clk);
      #1;
      bus.d_edge        = 1'b0;
      bus.shift_enable  = 1'b0;
      bus.byte_received = 1'b0;
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   // Eight bit samples separated by idle cycles, then the byte_received pulse;
   // returns right after the pulse has been clocked in
   task automatic sendByte(input logic [7:0] data);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
         if (i < 7) begin
            idleCycle();
         end
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, data);
   endtask

   // A data byte that must produce exactly one write strobe
   task automatic sendData(input string tag, input logic [7:0] data);
      sendByte(data);
      checkOutput({tag, "_wen_high"}, 32'(bus.w_enable), 32'd1);
      idleCycle();
      checkOutput({tag, "_wen_low"}, 32'(bus.w_enable), 32'd0);
   endtask

   // Complete well-formed packet with two data bytes
   task automatic runValidPacket(input string tag, input logic [7:0] b0,
                                 input logic [7:0] b1);
      w_base  = w_count;
      pd_base = pd_count;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput({tag, "_rcving_start"}, 32'(bus.rcving), 32'd1);
      checkOutput({tag, "_rerr_start"}, 32'(bus.r_error), 32'd0);
      sendByte(8'h80);
      idleCycle();
      sendData({tag, "_b0"}, b0);
      sendData({tag, "_b1"}, b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
      checkOutput({tag, "_pd_eop1"}, 32'(bus.packet_done), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
      checkOutput({tag, "_pd_high"}, 32'(bus.packet_done), 32'd1);
      idleCycle();
      checkOutput({tag, "_pd_low"}, 32'(bus.packet_done), 32'd0);
      checkOutput({tag, "_rcving_linewait"}, 32'(bus.rcving), 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput({tag, "_rcving_end"}, 32'(bus.rcving), 32'd0);
      checkOutput({tag, "_rerr_end"}, 32'(bus.r_error), 32'd0);
      checkOutput({tag, "_wen_count"}, 32'(w_count - w_base), 32'd2);
      checkOutput({tag, "_pd_count"}, 32'(pd_count - pd_base), 32'd1);
   endtask

   // Directed test sequence
   initial begin
      check_count       = 0;
      fail_count        = 0;
      w_count           = 0;
      pd_count          = 0;
      n_rst             = 1'b0;
      bus.d_edge        = 1'b0;
      bus.eop           = 1'b0;
      bus.shift_enable  = 1'b0;
      bus.byte_received = 1'b0;
      bus.rcv_data      = 8'h00;

      #2;
      checkOutput("reset_rcving", 32'(bus.rcving), 32'd0);
      checkOutput("reset_wen", 32'(bus.w_enable), 32'd0);
      checkOutput("reset_rerr", 32'(bus.r_error), 32'd0);
      checkOutput("reset_pd", 32'(bus.packet_done), 32'd0);
      @(negedge clk);
      n_rst = 1'b1;

      $display("[TB] valid packet");
      runValidPacket("valid", 8'hA5, 8'h3C);

      $display("[TB] bad SYNC");
      w_base = w_count;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      sendByte(8'h81);
      checkOutput("badsync_rerr", 32'(bus.r_error), 32'd1);
      checkOutput("badsync_wen", 32'(bus.w_enable), 32'd0);
      checkOutput("badsync_rcving", 32'(bus.rcving), 32'd1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
      checkOutput("badsync_eidle_rerr", 32'(bus.r_error), 32'd1);
      checkOutput("badsync_eidle_rcving", 32'(bus.rcving), 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("badsync_idle_rerr", 32'(bus.r_error), 32'd1);
      idleCycle();
      checkOutput("badsync_idle2_rerr", 32'(bus.r_error), 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("badsync_clear_rerr", 32'(bus.r_error), 32'd0);
      checkOutput("badsync_clear_rcving", 32'(bus.rcving), 32'd1);
      checkOutput("badsync_wen_count", 32'(w_count - w_base), 32'd0);

      $display("[TB] EOP mid-byte");
      w_base = w_count;
      sendByte(8'h80);
      idleCycle();
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      idleCycle();
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      idleCycle();
      checkOutput("midbyte_pre_rerr", 32'(bus.r_error), 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
      checkOutput("midbyte_rerr", 32'(bus.r_error), 32'd1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      checkOutput("midbyte_idle_rerr", 32'(bus.r_error), 32'd1);
      checkOutput("midbyte_wen_count", 32'(w_count - w_base), 32'd0);

      $display("[TB] single-bit EOP");
      pd_base = pd_count;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      sendByte(8'h80);
      idleCycle();
      sendData("seop_b0", 8'h11);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
      checkOutput("seop_eop2_rerr", 32'(bus.r_error), 32'd0);
      idleCycle();
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      checkOutput("seop_rerr", 32'(bus.r_error), 32'd1);
      checkOutput("seop_pd", 32'(bus.packet_done), 32'd0);
      checkOutput("seop_pd_count", 32'(pd_count - pd_base), 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

      $display("[TB] reset mid-packet");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      sendByte(8'h80);
      idleCycle();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
         idleCycle();
      end
      checkOutput("rst_pre_rcving", 32'(bus.rcving), 32'd1);
      #2;
      n_rst = 1'b0;
      #1;
      checkOutput("rst_async_rcving", 32'(bus.rcving), 32'd0);
      checkOutput("rst_async_wen", 32'(bus.w_enable), 32'd0);
      checkOutput("rst_async_rerr", 32'(bus.r_error), 32'd0);
      checkOutput("rst_async_pd", 32'(bus.packet_done), 32'd0);
      @(negedge clk);
      n_rst = 1'b1;
      runValidPacket("afterrst", 8'h5A, 8'hC3);

`ifdef RCV_LEN_CHECK_EN
      $display("[TB] length limit");
      w_base = w_count;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      sendByte(8'h80);
      idleCycle();
      sendData("len_b0", 8'h01);
      sendData("len_b1", 8'h02);
      sendByte(8'h03);
      checkOutput("len_b2_wen", 32'(bus.w_enable), 32'd0);
      checkOutput("len_b2_rerr", 32'(bus.r_error), 32'd1);
      idleCycle();
      checkOutput("len_wen_count", 32'(w_count - w_base), 32'd2);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
`endif

      idleCycle();
      $display("End of test - %0d assertions evaluated, %0d failures",
               check_count, fail_count);
      $finish;
   end

endmodule
